// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : aes_pkg
// Brief    : Shared AES-128 types, S-box/Rcon tables and byte/word helpers.
// Revision : 1.0 - initial release
// ============================================================================
package aes_pkg;

    // state[r][c] holds byte 4c+r of the 128-bit block
    typedef logic [3:0][3:0][7:0] aes_state_t;

    // Forward S-box; element 0 is the leftmost byte of the literal
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Round constants indexed by absolute round number 1..10
    localparam logic [1:10][7:0] RCON = 80'h01020408102040801b36;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic aes_state_t to_state(input logic [127:0] d);
        aes_state_t s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                s[r][c] = d[127 - 8*(4*c + r) -: 8];
            end
        end
        return s;
    endfunction

    function automatic logic [127:0] from_state(input aes_state_t s);
        logic [127:0] d;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                d[127 - 8*(4*c + r) -: 8] = s[r][c];
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_step.sv
`default_nettype none
// ============================================================================
// Module   : aes_round_step
// Brief    : One combinational AES-128 encryption round plus the matching
//            key-schedule step (next round key is produced and applied here).
// Revision : 1.0 - initial release
// ============================================================================
module aes_round_step
    import aes_pkg::*;
(
    input  aes_state_t   st,
    input  logic [127:0] rk,
    input  logic [3:0]   round_num,
    input  logic         is_final,
    output aes_state_t   st_next,
    output logic [127:0] rk_next
);

    logic [7:0]  w_rcon;
    logic [31:0] w_w0;
    logic [31:0] w_w1;
    logic [31:0] w_w2;
    logic [31:0] w_w3;
    aes_state_t  w_sb;
    aes_state_t  w_sr;
    aes_state_t  w_mc;

    // Advance the round key by one schedule step for absolute round round_num
    always_comb begin
        w_rcon = 8'h00;
        if ((round_num >= 4'd1) && (round_num <= 4'd10)) begin
            w_rcon = RCON[round_num];
        end
        w_w0    = rk[127:96] ^ sub_word(rot_word(rk[31:0])) ^ {w_rcon, 24'h000000};
        w_w1    = rk[95:64] ^ w_w0;
        w_w2    = rk[63:32] ^ w_w1;
        w_w3    = rk[31:0]  ^ w_w2;
        rk_next = {w_w0, w_w1, w_w2, w_w3};
    end

    // SubBytes, ShiftRows, MixColumns (skipped in the final round), AddRoundKey
    always_comb begin
        w_sb = '0;
        w_sr = '0;
        w_mc = '0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_sb[r][c] = SBOX[st[r][c]];
            end
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                w_sr[r][c] = w_sb[r][(c + r) % 4];
            end
        end
        for (int c = 0; c < 4; c++) begin
            w_mc[0][c] = xtime(w_sr[0][c]) ^ xtime(w_sr[1][c]) ^ w_sr[1][c]
                       ^ w_sr[2][c] ^ w_sr[3][c];
            w_mc[1][c] = w_sr[0][c] ^ xtime(w_sr[1][c]) ^ xtime(w_sr[2][c])
                       ^ w_sr[2][c] ^ w_sr[3][c];
            w_mc[2][c] = w_sr[0][c] ^ w_sr[1][c] ^ xtime(w_sr[2][c])
                       ^ xtime(w_sr[3][c]) ^ w_sr[3][c];
            w_mc[3][c] = xtime(w_sr[0][c]) ^ w_sr[0][c] ^ w_sr[1][c]
                       ^ w_sr[2][c] ^ xtime(w_sr[3][c]);
        end
        st_next = (is_final ? w_sr : w_mc) ^ to_state(rk_next);
    end

endmodule
`default_nettype wire

// File: rtl/aes_encr_iter.sv
`default_nettype none
// ============================================================================
// Module   : aes_encr_iter
// Brief    : Iterative AES-128 encryptor, UNROLL rounds per clock, on-the-fly
//            key schedule, valid/ready handshakes on input and output.
// Revision : 1.0 - initial release
// ============================================================================
module aes_encr_iter
    import aes_pkg::*;
#(
    parameter int UNROLL = 1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam logic [1:0] C_IDLE = 2'd0;
    localparam logic [1:0] C_RUN  = 2'd1;
    localparam logic [1:0] C_DONE = 2'd2;
    localparam logic [3:0] C_STEP = 4'(UNROLL);
    localparam logic [3:0] C_LAST = 4'd10;

    // Only divisors of 10 give a whole number of cycles per block
    if (!((UNROLL == 1) || (UNROLL == 2) || (UNROLL == 5) || (UNROLL == 10))) begin : g_bad_unroll
        $error("aes_encr_iter: UNROLL must be 1, 2, 5 or 10");
    end

    logic [1:0]   r_state;
    logic [1:0]   w_state_next;
    aes_state_t   r_st;
    logic [127:0] r_rk;
    logic [3:0]   r_rnd;
    logic [127:0] r_out_data;
    logic         w_accept;
    logic         w_last;

    aes_state_t   w_st_chain [UNROLL+1];
    logic [127:0] w_rk_chain [UNROLL+1];

    assign w_st_chain[0] = r_st;
    assign w_rk_chain[0] = r_rk;
    assign w_accept      = in_valid & in_ready;
    assign w_last        = ((r_rnd + C_STEP) == C_LAST);
    assign out_data      = r_out_data;

    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [3:0] w_num;
        assign w_num = r_rnd + 4'(k + 1);
        aes_round_step u_step (
            .st        (w_st_chain[k]),
            .rk        (w_rk_chain[k]),
            .round_num (w_num),
            .is_final  (w_num == C_LAST),
            .st_next   (w_st_chain[k+1]),
            .rk_next   (w_rk_chain[k+1])
        );
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= C_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            C_IDLE: if (w_accept) w_state_next = C_RUN;
            C_RUN:  if (w_last)   w_state_next = C_DONE;
            C_DONE: begin
                if (out_ready) begin
                    w_state_next = in_valid ? C_RUN : C_IDLE;
                end
            end
            default: w_state_next = C_IDLE;
        endcase
    end

    // Handshake and status outputs decoded from the state
    always_comb begin
        in_ready  = (r_state == C_IDLE) || ((r_state == C_DONE) && out_ready);
        out_valid = (r_state == C_DONE);
        busy      = (r_state == C_RUN) || (r_state == C_DONE);
    end

    // Datapath: load on accept, iterate while running, capture ciphertext on the last pass
    always_ff @(posedge clk) begin
        if (rst) begin
            r_st       <= '0;
            r_rk       <= '0;
            r_rnd      <= '0;
            r_out_data <= '0;
        end else if (w_accept) begin
            r_st  <= to_state(in_data ^ in_key);
            r_rk  <= in_key;
            r_rnd <= '0;
        end else if (r_state == C_RUN) begin
            r_st  <= w_st_chain[UNROLL];
            r_rk  <= w_rk_chain[UNROLL];
            r_rnd <= r_rnd + C_STEP;
            if (w_last) begin
                r_out_data <= from_state(w_st_chain[UNROLL]);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_aes_encr_iter.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_encr_iter
// Brief    : Self-checking bench for aes_encr_iter with an output scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_encr_iter;

    localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] AB_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] AB_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] AB_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] Z_CT   = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic         busy;

    logic         aux_in_valid;
    logic [127:0] aux_in_data;
    logic [127:0] aux_in_key;
    logic         aux_in_ready  [3];
    logic         aux_out_valid [3];
    logic [127:0] aux_out_data  [3];
    logic         aux_busy      [3];

    int           checks   = 0;
    int           errors   = 0;
    int           hs_count = 0;
    logic [127:0] sb_q [$];

    always #5 clk = ~clk;

    aes_encr_iter #(.UNROLL(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    for (genvar g = 0; g < 3; g++) begin : g_aux
        aes_encr_iter #(.UNROLL(g == 0 ? 2 : (g == 1 ? 5 : 10))) u_aux (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (aux_in_valid),
            .in_ready  (aux_in_ready[g]),
            .in_data   (aux_in_data),
            .in_key    (aux_in_key),
            .out_valid (aux_out_valid[g]),
            .out_ready (1'b1),
            .out_data  (aux_out_data[g]),
            .busy      (aux_busy[g])
        );
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every output handshake pops and checks the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            hs_count++;
            check("sb_nonempty", 128'(sb_q.size() != 0), 128'd1);
            if (sb_q.size() != 0) begin
                check("out_data", out_data, sb_q.pop_front());
            end
        end
    end

    // Offer one block and hold it until accepted; reports whether the accept
    // coincided with an output handshake
    task automatic send(input logic [127:0] d, input logic [127:0] k, input logic [127:0] exp,
                        input bit push, input bit hold, output bit coinc);
        bit acc;
        acc   = 1'b0;
        coinc = 1'b0;
        in_data  = d;
        in_key   = k;
        in_valid = 1'b1;
        for (int i = 0; i < 40 && !acc; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc   = 1'b1;
                coinc = out_valid && out_ready;
                if (push) sb_q.push_back(exp);
            end
            @(posedge clk);
            #1;
        end
        if (!hold) in_valid = 1'b0;
        check("accept", 128'(acc), 128'd1);
    endtask

    // Cycles from the accept edge until out_valid is seen
    task automatic wait_out(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check("sb_drain", 128'(sb_q.size()), 128'd0);
    endtask

    initial begin
        int lat;
        int hs0;
        int aux_lat [3];
        logic [127:0] aux_res [3];
        bit c;

        rst          = 1'b1;
        in_valid     = 1'b0;
        out_ready    = 1'b1;
        in_data      = '0;
        in_key       = '0;
        aux_in_valid = 1'b0;
        aux_in_data  = '0;
        aux_in_key   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_busy",      128'(busy),      128'd0);
        check("rst_out_data",  out_data,        128'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", 128'(in_ready), 128'd1);

        // App.B on the UNROLL = 2, 5, 10 instances, launched on the same edge
        for (int i = 0; i < 3; i++) begin
            aux_lat[i] = -1;
            aux_res[i] = '0;
            check("aux_in_ready", 128'(aux_in_ready[i]), 128'd1);
        end
        aux_in_data  = AB_PT;
        aux_in_key   = AB_KEY;
        aux_in_valid = 1'b1;
        @(posedge clk);
        #1;
        aux_in_valid = 1'b0;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < 3; i++) begin
                if (aux_out_valid[i] && aux_lat[i] < 0) begin
                    aux_lat[i] = cyc;
                    aux_res[i] = aux_out_data[i];
                end
            end
        end
        check("aux2_lat",  128'(aux_lat[0]), 128'd5);
        check("aux2_ct",   aux_res[0], AB_CT);
        check("aux5_lat",  128'(aux_lat[1]), 128'd2);
        check("aux5_ct",   aux_res[1], AB_CT);
        check("aux10_lat", 128'(aux_lat[2]), 128'd1);
        check("aux10_ct",  aux_res[2], AB_CT);

        // C.1 and App.B on UNROLL = 1
        send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0, c);
        wait_out(lat);
        check("c1_latency", 128'(lat), 128'd10);
        drain();
        send(AB_PT, AB_KEY, AB_CT, 1'b1, 1'b0, c);
        wait_out(lat);
        check("appb_latency", 128'(lat), 128'd10);
        drain();

        // Back-pressure: hold the result for 7 cycles, then release once
        out_ready = 1'b0;
        send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0, c);
        wait_out(lat);
        check("bp_latency", 128'(lat), 128'd10);
        hs0 = hs_count;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_out_data",  out_data,          C1_CT);
            check("bp_out_valid", 128'(out_valid),   128'd1);
            check("bp_in_ready",  128'(in_ready),    128'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("bp_one_xfer",   128'(hs_count - hs0), 128'd1);
        check("bp_out_valid0", 128'(out_valid),      128'd0);
        check("bp_busy0",      128'(busy),           128'd0);

        // Back-to-back with in_valid held high across three blocks
        send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b1, c);
        send(AB_PT, AB_KEY, AB_CT, 1'b1, 1'b1, c);
        check("b2b_coinc2", 128'(c), 128'd1);
        send('0, '0, Z_CT, 1'b1, 1'b0, c);
        check("b2b_coinc3", 128'(c), 128'd1);
        drain();
        @(posedge clk);
        #1;

        // Reset during round 4 aborts the block
        send(C1_PT, C1_KEY, C1_CT, 1'b0, 1'b0, c);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 128'(out_valid), 128'd0);
        check("mid_rst_busy",      128'(busy),      128'd0);
        check("mid_rst_in_ready",  128'(in_ready),  128'd1);
        check("mid_rst_out_data",  out_data,        128'd0);
        send(C1_PT, C1_KEY, C1_CT, 1'b1, 1'b0, c);
        wait_out(lat);
        check("post_rst_latency", 128'(lat), 128'd10);
        drain();

        // Inputs scrambled every cycle while the block is in flight
        send(AB_PT, AB_KEY, AB_CT, 1'b1, 1'b0, c);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            in_data = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_key  = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
        check("stab_latency", 128'(lat), 128'd10);
        drain();

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
